// File: rtl/qam_demapper.sv
// 64-QAM receive demapper: frames FFT output, hard-slices enabled data bins to
// 6-bit symbols and repacks them MSB-first into B-bit bytes with carry-over.
module qam_demapper #(
    parameter int unsigned B          = 8,
    parameter int unsigned N          = 16,
    parameter int unsigned LOG2M      = 6,
    parameter int unsigned DATA_FIRST = 9,
    parameter int unsigned DATA_LAST  = 14,
    parameter int unsigned SB_SIZE    = 3,
    parameter int          T1         = 9354,
    parameter int          T2         = 18707,
    parameter int          T3         = 28060
) (
    input  logic         aclk,
    input  logic         reset_n,
    input  logic [7:0]   carrier_control,
    input  logic [31:0]  s_data_in,
    input  logic         s_dvalid,
    output logic         s_dready,
    input  logic         s_dlast,
    output logic [B-1:0] m_data_out,
    output logic         m_dvalid,
    input  logic         m_dready,
    output logic         m_dlast,
    output logic         frame_err,
    output logic [5:0]   m_bin_index
);

    localparam int unsigned FftInputs = 2 * N;
    localparam int unsigned CntW      = $clog2(B);
    localparam int unsigned CatW      = B + LOG2M;

    typedef enum logic [0:0] {StAcq, StRun} state_e;

    state_e             state_q;
    logic [5:0]         bin_q;
    logic               frame_err_q;

    logic [LOG2M-1:0]   sym_q;
    logic               sym_vld_q;
    logic               sym_last_q;

    logic [B-1:0]       acc_q, acc_d;
    logic [CntW-1:0]    acc_cnt_q, acc_cnt_d;
    logic [B-1:0]       m_data_out_q, m_data_out_d;
    logic               m_dvalid_q, m_dvalid_d;
    logic               m_dlast_q, m_dlast_d;

    logic               accept;
    logic               bin_last;
    logic               frame_mismatch;
    logic [63:0]        en_vec;
    logic [5:0]         last_bin;
    logic [CatW-1:0]    cat;
    logic [CatW-1:0]    rem_mask;
    int                 fill;

    // Map a signed axis value onto the Gray-coded 3-bit level code.
    function automatic logic [2:0] slice_axis(input logic signed [15:0] v);
        int sv;
        sv = int'(v);
        if (sv >= T3)       return 3'b100;  // +7
        else if (sv >= T2)  return 3'b101;  // +5
        else if (sv >= T1)  return 3'b111;  // +3
        else if (sv >= 0)   return 3'b110;  // +1
        else if (sv >= -T1) return 3'b010;  // -1
        else if (sv >= -T2) return 3'b011;  // -3
        else if (sv >= -T3) return 3'b001;  // -5
        else                return 3'b000;  // -7
    endfunction

    // A stalled output byte freezes every stage, including input acceptance.
    assign s_dready       = !m_dvalid_q || m_dready;
    assign accept         = s_dvalid && s_dready;
    assign bin_last       = (bin_q == 6'(FftInputs - 1));
    assign frame_mismatch = s_dlast ^ bin_last;

    // Per-bin enable from the sub-band mask; only data bins can ever be set.
    always_comb begin
        en_vec   = '0;
        last_bin = '0;
        for (int k = DATA_FIRST; k <= DATA_LAST; k++) begin
            en_vec[6'(k)] = carrier_control[3'((k - 3) / SB_SIZE + 3)];
        end
        for (int k = DATA_FIRST; k <= DATA_LAST; k++) begin
            if (en_vec[6'(k)]) last_bin = 6'(k);
        end
    end

    // Frame tracker: acquire on s_dlast, then count bins and flag length errors.
    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StAcq;
            bin_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    StAcq: begin
                        if (s_dlast) begin
                            state_q <= StRun;
                            bin_q   <= '0;
                        end
                    end
                    StRun: begin
                        if (frame_mismatch) begin
                            frame_err_q <= 1'b1;
                            bin_q       <= '0;
                        end else if (bin_last) begin
                            bin_q <= '0;
                        end else begin
                            bin_q <= bin_q + 6'd1;
                        end
                    end
                    default: state_q <= StAcq;
                endcase
            end
        end
    end

    // Stage 1: register the sliced symbol and whether it closes the frame's data.
    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) begin
            sym_q      <= '0;
            sym_vld_q  <= 1'b0;
            sym_last_q <= 1'b0;
        end else if (s_dready) begin
            sym_vld_q  <= accept && (state_q == StRun) && en_vec[bin_q];
            sym_last_q <= accept && (state_q == StRun) && en_vec[bin_q] && (bin_q == last_bin);
            sym_q      <= {slice_axis(s_data_in[31:16]), slice_axis(s_data_in[15:0])};
        end
    end

    // Stage 2 next state: append symbol to the accumulator, emit a byte once full.
    always_comb begin
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        m_data_out_d = m_data_out_q;
        m_dvalid_d   = 1'b0;
        m_dlast_d    = 1'b0;
        cat          = {acc_q, sym_q};
        fill         = int'(acc_cnt_q) + int'(LOG2M);
        rem_mask     = '0;
        if (sym_vld_q) begin
            if (fill >= int'(B)) begin
                // Unused accumulator bits stay zero, so the top B of 'fill' bits land low.
                rem_mask     = (CatW'(1) << (fill - int'(B))) - CatW'(1);
                m_data_out_d = B'(cat >> (fill - int'(B)));
                m_dvalid_d   = 1'b1;
                m_dlast_d    = sym_last_q;
                acc_d        = B'(cat & rem_mask);
                acc_cnt_d    = CntW'(fill - int'(B));
            end else begin
                acc_d        = B'(cat);
                acc_cnt_d    = CntW'(fill);
            end
        end
    end

    // Stage 2 registers: accumulator and the held output byte.
    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            m_data_out_q <= '0;
            m_dvalid_q   <= 1'b0;
            m_dlast_q    <= 1'b0;
        end else if (s_dready) begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            m_data_out_q <= m_data_out_d;
            m_dvalid_q   <= m_dvalid_d;
            m_dlast_q    <= m_dlast_d;
        end
    end

    assign m_data_out  = m_data_out_q;
    assign m_dvalid    = m_dvalid_q;
    assign m_dlast     = m_dlast_q;
    assign frame_err   = frame_err_q;
    assign m_bin_index = bin_q;

endmodule
